// File: rtl/keypad_matrix_scanner.sv
// Row-scanning matrix keypad controller with frame debounce and chord rejection.
// Optional auto-repeat on a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner #(
    parameter int CLK_HZ             = 50000000,
    parameter int SCAN_HZ            = 1000,
    parameter int ROWS               = 4,
    parameter int COLS               = 4,
    parameter int DEBOUNCE_SCANS     = 20,
    parameter int ACTIVE_LOW         = 1,
    parameter int REPEAT_DELAY_SCANS = 500,
    parameter int REPEAT_RATE_SCANS  = 100,
    localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   matricial_col,
    output logic [ROWS-1:0]   matricial_lin,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_multi,
    output logic              key_repeat
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int NKEYS = ROWS * COLS;
    localparam logic [COLS-1:0] COL_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] idx);
        logic [ROWS-1:0] onehot;
        onehot = ROWS'(1) << idx;
        return (ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

    // Tick divider: one tick per row period.
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    logic [COLS-1:0] col_meta, col_sync, col_norm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= COL_IDLE;
            col_sync <= COL_IDLE;
        end else begin
            col_meta <= matricial_col;
            col_sync <= col_meta;
        end
    end

    assign col_norm = (ACTIVE_LOW != 0) ? ~col_sync : col_sync;

    logic [ROW_W-1:0] row_idx, row_nx;
    logic             last_row, frame_end;
    logic [NKEYS-1:0] frame, frame_full;

    assign last_row  = (row_idx == ROW_W'(ROWS - 1));
    assign frame_end = tick && last_row;
    assign row_nx    = last_row ? '0 : row_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx       <= '0;
            matricial_lin <= row_drive('0);
            frame         <= '0;
        end else if (tick) begin
            frame[row_idx*COLS +: COLS] <= col_norm;
            row_idx                     <= row_nx;
            matricial_lin               <= row_drive(row_nx);
        end
    end

    // The last row is classified straight from the synchronizer so the frame
    // decision is available on the same tick that completes it.
    logic [1:0]        hits;
    logic [CODE_W-1:0] code_single;
    logic              is_none, is_single, is_multi;

    always_comb begin
        frame_full                       = frame;
        frame_full[row_idx*COLS +: COLS] = col_norm;
        hits        = 2'd0;
        code_single = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (frame_full[i]) begin
                if (hits != 2'd2) hits = hits + 2'd1;
                code_single = CODE_W'(i);
            end
        end
    end

    assign is_none   = (hits == 2'd0);
    assign is_single = (hits == 2'd1);
    assign is_multi  = (hits == 2'd2);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic [CODE_W-1:0] cand, cand_nx, code_nx;
    logic              valid_nx, repeat_nx;

    assign cnt_inc  = cnt + 1'b1;
    assign key_held = (state == PRESSED) || (state == DEB_REL);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                             REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_nx, rep_inc, rep_thr;
    logic             rep_started, rep_started_nx;

    assign rep_inc = rep_cnt + 1'b1;
    assign rep_thr = rep_started ? REP_W'(REPEAT_RATE_SCANS) : REP_W'(REPEAT_DELAY_SCANS);
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cand_nx   = cand;
        code_nx   = key_code;
        valid_nx  = 1'b0;
        repeat_nx = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nx     = rep_cnt;
        rep_started_nx = rep_started;
`endif
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_nx = code_single;
                        if (DEBOUNCE_SCANS == 1) begin
                            code_nx  = code_single;
                            valid_nx = 1'b1;
                            state_nx = PRESSED;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx   = CNT_W'(1);
                            state_nx = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (is_single && code_single == cand) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            code_nx  = cand;
                            valid_nx = 1'b1;
                            state_nx = PRESSED;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = DEB_REL;
                            cnt_nx   = CNT_W'(1);
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (is_single && code_single == key_code) begin
                        if (rep_inc == rep_thr) begin
                            valid_nx       = 1'b1;
                            repeat_nx      = 1'b1;
                            rep_cnt_nx     = '0;
                            rep_started_nx = 1'b1;
                        end else begin
                            rep_cnt_nx = rep_inc;
                        end
                    end else begin
                        rep_cnt_nx     = '0;
                        rep_started_nx = 1'b0;
                    end
`endif
                end
                DEB_REL: begin
                    if (is_none) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        state_nx = PRESSED;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state != PRESSED) begin
            rep_cnt_nx     = '0;
            rep_started_nx = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_multi <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            if (frame_end) key_multi <= is_multi;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt     <= '0;
            rep_started <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            rep_cnt     <= rep_cnt_nx;
            rep_started <= rep_started_nx;
            key_repeat  <= repeat_nx;
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule
